// File: rtl/uarc_bus_link.sv
// uarc_bus_link: one UARC point-to-point channel from a sender core to a receiver core.
// Latches a single prioritised request with its payload and handshakes both sides, with a timeout fault.
module uarc_bus_link #(
   parameter int  WORD_MAG    = 5,
   parameter int  TIMEOUT_MAG = 8,
   localparam int WORD_WIDTH  = 1 << WORD_MAG
) (
   input  logic                  clk,
   input  logic                  reset,
   // sender side
   input  logic                  s_enable,
   input  logic                  s_kill,
   input  logic                  s_incept,
   input  logic                  s_send,
   input  logic                  s_stream,
   input  logic [WORD_WIDTH-1:0] s_data,
   input  logic [WORD_WIDTH-1:0] s_self_permission,
   input  logic [WORD_WIDTH-1:0] s_self_address,
   input  logic [WORD_WIDTH-1:0] s_incept_permission,
   input  logic [WORD_WIDTH-1:0] s_incept_address,
   output logic                  s_kill_ack,
   output logic                  s_incept_ack,
   output logic                  s_send_ack,
   output logic                  s_stream_ack,
   output logic                  s_fault,
   // receiver side
   output logic                  r_enable,
   output logic                  r_kill,
   output logic                  r_incept,
   output logic                  r_send,
   output logic                  r_stream,
   output logic [WORD_WIDTH-1:0] r_data,
   output logic [WORD_WIDTH-1:0] r_self_permission,
   output logic [WORD_WIDTH-1:0] r_self_address,
   output logic [WORD_WIDTH-1:0] r_incept_permission,
   output logic [WORD_WIDTH-1:0] r_incept_address,
   input  logic                  r_kill_ack,
   input  logic                  r_incept_ack,
   input  logic                  r_send_ack,
   input  logic                  r_stream_ack,
   // status
   output logic                  busy,
   output logic [WORD_WIDTH-1:0] xfer_count
);

   typedef enum logic [1:0] {IDLE, PRESENT, DONE, FAULT} state_t;

   localparam logic [TIMEOUT_MAG-1:0] TIMER_LAST = '1;

   state_t                 state, state_nx;
   logic [3:0]             req_vec, rack_vec;
   logic [3:0]             typ, typ_nx;
   logic [TIMEOUT_MAG-1:0] timer, timer_nx, timer_inc;
   logic [WORD_WIDTH-1:0]  count, count_nx;
   logic                   held, matched, load;

   logic [3:0]             rreq_nx, sack_nx;
   logic                   vld_nx, fault_nx;

   logic [3:0]             rreq_p1, sack_p1;
   logic                   vld_p1, fault_p1, busy_p1;
   logic [WORD_WIDTH-1:0]  data_p1, sperm_p1, saddr_p1, iperm_p1, iaddr_p1;

   // Bit order everywhere: {kill, incept, send, stream}, kill most urgent.
   assign req_vec  = {s_kill, s_incept, s_send, s_stream};
   assign rack_vec = {r_kill_ack, r_incept_ack, r_send_ack, r_stream_ack};

   function automatic logic [3:0] pick_type(input logic [3:0] req);
      if (req[3])      return 4'b1000;
      else if (req[2]) return 4'b0100;
      else if (req[1]) return 4'b0010;
      else if (req[0]) return 4'b0001;
      else             return 4'b0000;
   endfunction

   assign matched   = |(typ & rack_vec);
   assign held      = s_enable && |(typ & req_vec);
   assign timer_inc = timer + TIMEOUT_MAG'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         typ   <= '0;
         timer <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         typ   <= typ_nx;
         timer <= timer_nx;
         count <= count_nx;
      end
   end

   always_comb begin
      state_nx = state;
      typ_nx   = typ;
      timer_nx = timer;
      count_nx = count;
      load     = 1'b0;
      rreq_nx  = '0;
      sack_nx  = '0;
      vld_nx   = 1'b0;
      fault_nx = 1'b0;
      case (state)
         IDLE: begin
            // A receiver still acking the previous transfer blocks the next launch.
            if (s_enable && (|req_vec) && !(|rack_vec)) begin
               state_nx = PRESENT;
               typ_nx   = pick_type(req_vec);
               timer_nx = '0;
               load     = 1'b1;
               vld_nx   = 1'b1;
               rreq_nx  = pick_type(req_vec);
            end
         end
         PRESENT: begin
            // A matching ack on the expiry cycle still completes the transfer.
            if (matched) begin
               state_nx = DONE;
               count_nx = count + WORD_WIDTH'(1);
               sack_nx  = typ;
            end else if (timer_inc == TIMER_LAST) begin
               state_nx = FAULT;
               fault_nx = 1'b1;
            end else begin
               timer_nx = timer_inc;
               vld_nx   = 1'b1;
               rreq_nx  = typ;
            end
         end
         DONE: begin
            if (held) sack_nx  = typ;
            else      state_nx = IDLE;
         end
         FAULT: begin
            if (held) fault_nx = 1'b1;
            else      state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Stage p1: registered receiver strobes, sender acks and status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         rreq_p1  <= '0;
         sack_p1  <= '0;
         fault_p1 <= 1'b0;
         busy_p1  <= 1'b0;
      end else begin
         vld_p1   <= vld_nx;
         rreq_p1  <= rreq_nx;
         sack_p1  <= sack_nx;
         fault_p1 <= fault_nx;
         busy_p1  <= (state_nx != IDLE);
      end
   end

   // Stage p1: payload captured once at launch and held for the whole transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_p1  <= '0;
         sperm_p1 <= '0;
         saddr_p1 <= '0;
         iperm_p1 <= '0;
         iaddr_p1 <= '0;
      end else if (load) begin
         data_p1  <= s_data;
         sperm_p1 <= s_self_permission;
         saddr_p1 <= s_self_address;
         iperm_p1 <= s_incept_permission;
         iaddr_p1 <= s_incept_address;
      end
   end

   assign r_enable            = vld_p1;
   assign {r_kill, r_incept, r_send, r_stream} = rreq_p1;
   assign {s_kill_ack, s_incept_ack, s_send_ack, s_stream_ack} = sack_p1;
   assign s_fault             = fault_p1;
   assign busy                = busy_p1;
   assign xfer_count          = count;
   assign r_data              = data_p1;
   assign r_self_permission   = sperm_p1;
   assign r_self_address      = saddr_p1;
   assign r_incept_permission = iperm_p1;
   assign r_incept_address    = iaddr_p1;

endmodule
